// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage with a multi-cycle data memory. A memory access stalls upstream
// for LATENCY cycles; the writeback register then presents the load or ALU result.
module mem_wb_stage #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ALU_Res_i,
  input  logic [31:0] Write_Data_i,
  input  logic [4:0]  RdAddr_i,
  input  logic        MemToReg_i,
  input  logic        RegWrite_i,
  input  logic        MemWrite_i,
  output logic        stall_o,
  output logic [31:0] WB_Data_o,
  output logic [4:0]  RdAddr_o,
  output logic        RegWrite_o,
  output logic        err_o
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           mem_q [Words];
  logic [31:0]           wb_data_q, wb_data_d;
  logic [4:0]            rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic                  err_q, err_d;
  logic                  memop;
  logic                  complete;
  logic                  stall;
  logic [DEPTH_LOG2-1:0] idx;

  assign memop = MemToReg_i | MemWrite_i;
  assign idx   = ALU_Res_i[DEPTH_LOG2+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      StIdle: begin
        if (memop) begin
          stall   = 1'b1;
          state_d = StBusy;
          cnt_d   = 3'(LATENCY - 1);
        end else begin
          complete = 1'b1;
        end
      end
      StBusy: begin
        if (cnt_q != 3'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 3'd1;
        end else begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outside a completion cycle the stage emits a bubble and holds data/destination.
  always_comb begin
    wb_data_d = wb_data_q;
    rd_d      = rd_q;
    rw_d      = 1'b0;
    err_d     = 1'b0;
    if (complete) begin
      rd_d = RdAddr_i;
      if (MemWrite_i) begin
        rw_d = 1'b0;
      end else if (MemToReg_i) begin
        wb_data_d = mem_q[idx];
        rw_d      = RegWrite_i;
      end else begin
        wb_data_d = ALU_Res_i;
        rw_d      = RegWrite_i;
      end
      if (RdAddr_i == 5'd0) begin
        rw_d = 1'b0;
      end
      err_d = memop & ((MemToReg_i & MemWrite_i) | (|ALU_Res_i[1:0]));
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      wb_data_q <= 32'd0;
      rd_q      <= 5'd0;
      rw_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(Words); i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (complete && MemWrite_i) begin
      mem_q[idx] <= Write_Data_i;
    end
  end

  assign stall_o    = stall;
  assign WB_Data_o  = wb_data_q;
  assign RdAddr_o   = rd_q;
  assign RegWrite_o = rw_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: the driver queues expected writebacks, a monitor
// compares them on each completion and checks for bubbles elsewhere.
module tb_mem_wb_stage;

  typedef struct {
    logic [31:0] data;
    logic        chk;
    logic [4:0]  rd;
    logic        rw;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_res = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  rd_in = '0;
  logic        m2r = 1'b0;
  logic        rw_in = 1'b0;
  logic        mw = 1'b0;
  logic        stall_o;
  logic [31:0] wb_data_o;
  logic [4:0]  rd_o;
  logic        rw_o;
  logic        err_o;

  int   cmp_cnt = 0;
  int   mis_cnt = 0;
  logic tb_valid = 1'b0;
  logic pending = 1'b0;
  exp_t exp_q[$];

  mem_wb_stage #(
    .LATENCY   (2),
    .DEPTH_LOG2(5)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .ALU_Res_i   (alu_res),
    .Write_Data_i(wdata),
    .RdAddr_i    (rd_in),
    .MemToReg_i  (m2r),
    .RegWrite_i  (rw_in),
    .MemWrite_i  (mw),
    .stall_o     (stall_o),
    .WB_Data_o   (wb_data_o),
    .RdAddr_o    (rd_o),
    .RegWrite_o  (rw_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_nop();
    alu_res = '0;
    wdata   = '0;
    rd_in   = '0;
    m2r     = 1'b0;
    rw_in   = 1'b0;
    mw      = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the op.
  task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input logic m, input logic rw, input logic w, input int exp_stall,
                       input logic [31:0] e_data, input logic e_chk, input logic [4:0] e_rd,
                       input logic e_rw, input logic e_err);
    exp_t e;
    int   n;
    logic done;
    e.data = e_data;
    e.chk  = e_chk;
    e.rd   = e_rd;
    e.rw   = e_rw;
    e.err  = e_err;
    exp_q.push_back(e);
    alu_res  = alu;
    wdata    = wd;
    rd_in    = rd;
    m2r      = m;
    rw_in    = rw;
    mw       = w;
    tb_valid = 1'b1;
    n        = 0;
    done     = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (!stall_o) begin
        done = 1'b1;
        break;
      end
      n++;
    end
    if (!done) begin
      mis_cnt++;
      $display("FAIL stall_timeout: stall_o still high after %0d cycles, required %0d", n,
               exp_stall);
    end
    check("stall_cycles", 32'(n), 32'(exp_stall));
    @(posedge clk);
    #1;
    tb_valid = 1'b0;
    drive_nop();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (pending) begin
        if (exp_q.size() == 0) begin
          mis_cnt++;
          $display("FAIL scoreboard_empty: completion seen with no expected entry");
        end else begin
          e = exp_q.pop_front();
          if (e.chk) begin
            check("wb_data", wb_data_o, e.data);
            check("rd_addr", 32'(rd_o), 32'(e.rd));
          end
          check("reg_write", 32'(rw_o), 32'(e.rw));
          check("err", 32'(err_o), 32'(e.err));
        end
      end else begin
        check("bubble_reg_write", 32'(rw_o), 32'd0);
        check("bubble_err", 32'(err_o), 32'd0);
      end
      pending = tb_valid && !stall_o && rst_n;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    drive_nop();
    #1;
    check("rst_wb_data", wb_data_o, 32'd0);
    check("rst_rd_addr", 32'(rd_o), 32'd0);
    check("rst_reg_write", 32'(rw_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(32'h1234, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 0, 32'h1234, 1'b1, 5'd3, 1'b1, 1'b0);
    issue(32'h08, 32'hDEADBEEF, 5'd7, 1'b0, 1'b0, 1'b1, 2, 32'h0, 1'b0, 5'd7, 1'b0, 1'b0);
    issue(32'h08, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 2, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 1'b0);
    issue(32'h0A, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 2, 32'hDEADBEEF, 1'b1, 5'd6, 1'b1, 1'b1);
    issue(32'h10, 32'h55, 5'd8, 1'b1, 1'b1, 1'b1, 2, 32'h0, 1'b0, 5'd8, 1'b0, 1'b1);
    issue(32'h10, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2, 32'h55, 1'b1, 5'd9, 1'b1, 1'b0);
    issue(32'h08, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 2, 32'hDEADBEEF, 1'b1, 5'd0, 1'b0, 1'b0);
    issue(32'hABCD, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 0, 32'hABCD, 1'b1, 5'd0, 1'b0, 1'b0);
    issue(32'h14, 32'hCAFEF00D, 5'd1, 1'b0, 1'b0, 1'b1, 2, 32'h0, 1'b0, 5'd1, 1'b0, 1'b0);
    issue(32'h14, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 2, 32'hCAFEF00D, 1'b1, 5'd10, 1'b1, 1'b0);
    issue(32'h88, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 2, 32'hDEADBEEF, 1'b1, 5'd12, 1'b1, 1'b0);
    issue(32'h17, 32'h11, 5'd2, 1'b0, 1'b1, 1'b1, 2, 32'h0, 1'b0, 5'd2, 1'b0, 1'b1);
    issue(32'h14, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 2, 32'h11, 1'b1, 5'd13, 1'b1, 1'b0);

    // Store abandoned by reset one cycle into its stall.
    alu_res = 32'h0C;
    wdata   = 32'h77;
    rd_in   = 5'd4;
    mw      = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("stall_in_reset", 32'(stall_o), 32'd1);
    check("midrst_wb_data", wb_data_o, 32'd0);
    check("midrst_rd_addr", 32'(rd_o), 32'd0);
    check("midrst_reg_write", 32'(rw_o), 32'd0);
    check("midrst_err", 32'(err_o), 32'd0);
    drive_nop();
    #1;
    check("nop_stall_in_reset", 32'(stall_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(32'h0C, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 2, 32'h0, 1'b1, 5'd11, 1'b1, 1'b0);
    issue(32'h08, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 2, 32'h0, 1'b1, 5'd14, 1'b1, 1'b0);
    issue(32'h5A, 32'h0, 5'd31, 1'b0, 1'b1, 1'b0, 0, 32'h5A, 1'b1, 5'd31, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
